serial_frame_tx: RTL and testbench
==================================

# serial_frame_tx

Parallel-to-serial frame transmitter that drives a one-bit serial line for a downstream D flip-flop sampler/receiver. It accepts a WIDTH-bit word through a valid/ready handshake and emits one framed word: a start bit, the data bits LSB first, then a stop bit. Each bit is held for DIV clock cycles. It sits on the driving side of the lab's serial datapath and supplies the data_in stream that the capture flip-flops register.

## Interface
- WIDTH, default 8: data bits per frame, ≥1.
- DIV, default 1: clock cycles per serial bit, ≥1.

- clk  input  1  rising-edge clock; single clock domain.
- rst  input  1  reset; synchronous, active-low (asserted when 0, sampled on rising clk).
- load_data  input  WIDTH  word to transmit; sampled only on handshake.
- load_valid  input  1  producer has a word.
- load_ready  output  1  transmitter idle and able to accept.
- ser_out  output  1  serial line; idle level 1.
- ser_out_bar  output  1  always ~ser_out.
- busy  output  1  frame in progress (START, DATA or STOP).
- done  output  1  one-cycle pulse on the last cycle of the stop bit.

## Operation
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - ser_out=1, load_ready=1, busy=0.
  - A handshake (load_valid && load_ready at a rising edge) latches load_data into the shift register, clears the bit and tick counters, and moves to START.
- START: ser_out=0 for DIV cycles, then DATA.
- DATA:
  - ser_out = shift_reg[0] for DIV cycles per bit.
  - The register shifts right at the end of each bit period.
  - The bit counter runs from 0 to WIDTH-1. After bit WIDTH-1, the FSM moves to STOP.
- STOP:
  - ser_out=1 for DIV cycles.
  - done=1 on the final cycle of the stop bit, then IDLE.
- load_ready=0 in every state except IDLE. load_valid is ignored outside IDLE.
- load_data changing mid-frame has no effect on the frame in progress.
- All outputs are registered or decoded from registered state. No combinational path from inputs to outputs.
- Counter widths:
  - Bit counter: $clog2(WIDTH) bits, minimum 1.
  - Tick counter: $clog2(DIV) bits, minimum 1.
  - Both wrap to 0 at terminal count and never overflow.

## Timing
- Reset (rst=0 at an edge), from the next cycle:
  - state=IDLE, ser_out=1, ser_out_bar=0, busy=0, done=0.
  - load_ready=0 while rst=0, and 1 from the first cycle after rst returns to 1.
- Reset mid-frame aborts the frame immediately. The line returns to 1 on the next edge and no done pulse is issued.
- Handshake at edge N: ser_out=0 (start bit) from cycle N+1.
- Data bit k occupies cycles N+1+(k+1)·DIV through N+(k+2)·DIV.
- Frame length is (WIDTH+2)·DIV cycles. done is high in cycle N+(WIDTH+2)·DIV. load_ready returns to 1 the following cycle.
- Back-to-back frames: the earliest next handshake is the first IDLE cycle. That gives at least one idle cycle (line=1) between frames.
- If load_valid is held high continuously, frames repeat with a period of (WIDTH+2)·DIV+1 cycles.

## Structure
- Package serial_tx_pkg:
  - typedef enum logic [1:0] tx_state_t {IDLE, START, DATA, STOP}.
  - Constants: LINE_IDLE=1'b1, START_BIT=1'b0, STOP_BIT=1'b1.
- Sub-module bit_tick_counter:
  - Parameterized by DIV; inputs clk, rst, clear.
  - Output tick: 1 on the last cycle of each bit period.
  - Instantiated once. The FSM advances only on tick.
- Top level: FSM, shift register, bit counter, and output registers.

## Test plan
- Reset: hold rst=0 for 2 cycles with load_valid=1 -> ser_out=1, ser_out_bar=0, load_ready=0, busy=0, done=0. load_ready=1 one cycle after release.
- WIDTH=8, DIV=1, send 0xA5 -> ser_out over cycles N+1..N+10 = 0,1,0,1,0,0,1,0,1,1. done only at N+10. load_ready=1 at N+11.
- WIDTH=8, DIV=4, send 0x01 -> start low for 4 cycles, bit0 high for 4 cycles, bits 1–7 low for 28 cycles, stop high for 4 cycles. done at N+40.
- load_valid held high with two words, 0xFF then 0x00 -> second start bit at N+12 (DIV=1). load_data changes mid-frame do not alter frame 1. ser_out_bar is the exact inverse throughout.
- rst=0 asserted during DATA bit 3 -> ser_out=1 and busy=0 on the next cycle. No done pulse. A subsequent 0x3C frame transmits correctly.
- load_valid=0 idle for 20 cycles -> line stays 1, busy=0, no spurious done.

Source files
------------

// File: rtl/serial_tx_pkg.sv
// Shared types and constants for the framed serial transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bit_tick_counter.sv
// Bit-period timer: tick is high on the last of every DIV cycles.
// Latency: tick decoded from the registered count; clear takes effect next cycle.
// Backpressure: none; free-runs while clear is low.
//
// Ports: clk, rst (sync active-low), clear (hold count at 0), tick (out).
module bit_tick_counter
    import serial_tx_pkg::*;
#(
    parameter int unsigned DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int unsigned    CW   = cnt_width(DIV);
    localparam logic [CW-1:0]  TERM = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        tick  = (cnt_q == TERM);
        cnt_d = cnt_q + CW'(1);
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_frame_tx.sv
// Parallel-to-serial framer: start bit, WIDTH data bits LSB first, stop bit; DIV clocks per bit.
// Latency: start bit on the line the cycle after the handshake; frame lasts (WIDTH+2)*DIV cycles.
// Backpressure: load_ready only in IDLE; load_valid/load_data ignored while a frame is in flight.
//
// Ports: clk, rst (sync active-low), load_data/load_valid/load_ready (word input handshake),
//        ser_out/ser_out_bar (serial line, idle high), busy (frame in flight), done (last stop cycle).
module serial_frame_tx
    import serial_tx_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIV   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             ser_out,
    output logic             ser_out_bar,
    output logic             busy,
    output logic             done
);

    localparam int unsigned   BW       = cnt_width(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    tx_state_t        state_q;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_nxt;
    logic [BW-1:0]    bit_q;
    logic             ser_q;
    logic             busy_q;
    logic             ready_q;
    logic             tick;

    // Timer is held at zero while idle so the start bit gets a full period.
    bit_tick_counter #(
        .DIV (DIV)
    ) u_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (state_q == IDLE),
        .tick  (tick)
    );

    assign shift_nxt = shift_q >> 1;

    // The line value is registered one cycle ahead: each transition loads the
    // level the line must carry in the state being entered.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            ser_q   <= LINE_IDLE;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b1;
                    // ready_q is low for one cycle after reset, blocking a handshake then.
                    if (load_valid && ready_q) begin
                        shift_q <= load_data;
                        bit_q   <= '0;
                        state_q <= START;
                        ser_q   <= START_BIT;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                    end
                end
                START: begin
                    if (tick) begin
                        state_q <= DATA;
                        ser_q   <= shift_q[0];
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_q == LAST_BIT) begin
                            state_q <= STOP;
                            bit_q   <= '0;
                            ser_q   <= STOP_BIT;
                        end else begin
                            shift_q <= shift_nxt;
                            bit_q   <= bit_q + BW'(1);
                            ser_q   <= shift_nxt[0];
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        state_q <= IDLE;
                        ser_q   <= LINE_IDLE;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ser_q   <= LINE_IDLE;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign load_ready  = ready_q;
    assign ser_out     = ser_q;
    assign ser_out_bar = ~ser_q;
    assign busy        = busy_q;
    // tick comes from the registered count, so done has no input-to-output path.
    assign done        = (state_q == STOP) && tick;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: DUT 0 runs DIV=1, DUT 1 runs DIV=4, both WIDTH=8.
// Latency: n/a.
// Backpressure: driver waits on load_ready with a bounded cycle budget.
module tb_serial_frame_tx;

    typedef struct packed {
        logic ser;
        logic busy;
        logic done;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [7:0] ld_data  [2];
    logic       ld_valid [2];
    logic       rdy      [2];
    logic       so       [2];
    logic       sob      [2];
    logic       bsy      [2];
    logic       dn       [2];

    exp_t exp_q [2][$];
    logic exp_ready [2];
    int   checks;
    int   errors;

    serial_frame_tx #(.WIDTH(8), .DIV(1)) u_d1 (
        .clk         (clk),
        .rst         (rst),
        .load_data   (ld_data[0]),
        .load_valid  (ld_valid[0]),
        .load_ready  (rdy[0]),
        .ser_out     (so[0]),
        .ser_out_bar (sob[0]),
        .busy        (bsy[0]),
        .done        (dn[0])
    );

    serial_frame_tx #(.WIDTH(8), .DIV(4)) u_d4 (
        .clk         (clk),
        .rst         (rst),
        .load_data   (ld_data[1]),
        .load_valid  (ld_valid[1]),
        .load_ready  (rdy[1]),
        .ser_out     (so[1]),
        .ser_out_bar (sob[1]),
        .busy        (bsy[1]),
        .done        (dn[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected per-cycle line image of one frame, starting the cycle after the handshake.
    function automatic void push_frame(input int d, input logic [7:0] w);
        int   div;
        int   n;
        int   b;
        exp_t e;
        div = (d == 0) ? 1 : 4;
        n   = 10 * div;
        for (int c = 0; c < n; c++) begin
            b      = c / div;
            e.busy = 1'b1;
            e.done = (c == n - 1);
            if (b == 0)
                e.ser = 1'b0;
            else if (b <= 8)
                e.ser = w[b-1];
            else
                e.ser = 1'b1;
            exp_q[d].push_back(e);
        end
    endfunction

    // Monitor: one comparison per DUT per cycle, 1 time unit after the rising edge.
    task automatic check_cycle(input int d);
        exp_t e;
        logic er;
        if (exp_q[d].size() > 0) begin
            e  = exp_q[d].pop_front();
            er = 1'b0;
        end else begin
            e.ser  = 1'b1;
            e.busy = 1'b0;
            e.done = 1'b0;
            er     = exp_ready[d];
        end
        checks++;
        if (so[d] !== e.ser || sob[d] !== ~e.ser || bsy[d] !== e.busy ||
            dn[d] !== e.done || rdy[d] !== er) begin
            errors++;
            $display("FAIL line_dut%0d t=%0t: got ser=%b bar=%b busy=%b done=%b rdy=%b, want ser=%b bar=%b busy=%b done=%b rdy=%b",
                     d, $time, so[d], sob[d], bsy[d], dn[d], rdy[d],
                     e.ser, ~e.ser, e.busy, e.done, er);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            check_cycle(0);
            check_cycle(1);
        end
    end

    // Present a word; the frame is queued at the negedge before the handshake edge.
    task automatic send(input int d, input logic [7:0] w, input bit keep);
        int waited;
        waited      = 0;
        ld_data[d]  = w;
        ld_valid[d] = 1'b1;
        while (rdy[d] !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 100) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout dut%0d: load_ready=%b, want 1 within 100 cycles", d, rdy[d]);
            ld_valid[d] = 1'b0;
            return;
        end
        push_frame(d, w);
        @(negedge clk);
        if (!keep) ld_valid[d] = 1'b0;
    endtask

    task automatic wait_drain(input int d);
        int waited;
        waited = 0;
        while (exp_q[d].size() > 0 && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (exp_q[d].size() > 0) begin
            errors++;
            $display("FAIL drain_timeout dut%0d: %0d cycles left, want 0", d, exp_q[d].size());
            exp_q[d].delete();
        end
        @(negedge clk);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b0;
        ld_valid[0]  = 1'b1;
        ld_valid[1]  = 1'b1;
        ld_data[0]   = 8'h00;
        ld_data[1]   = 8'h00;
        exp_ready[0] = 1'b0;
        exp_ready[1] = 1'b0;

        // Reset held two cycles with load_valid asserted.
        repeat (2) @(negedge clk);
        rst          = 1'b1;
        ld_valid[0]  = 1'b0;
        ld_valid[1]  = 1'b0;
        exp_ready[0] = 1'b1;
        exp_ready[1] = 1'b1;
        @(negedge clk);

        // 0xA5 at DIV=1: line 0,1,0,1,0,0,1,0,1,1.
        send(0, 8'hA5, 1'b0);
        wait_drain(0);

        // 0x01 at DIV=4: done in the 40th frame cycle.
        send(1, 8'h01, 1'b0);
        wait_drain(1);

        // Back-to-back with load_valid held; data switches to 0x00 mid-frame 1.
        send(0, 8'hFF, 1'b1);
        send(0, 8'h00, 1'b0);
        wait_drain(0);

        // Reset during data bit 3 aborts the frame with no done pulse.
        send(0, 8'h96, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        exp_q[0].delete();
        exp_q[1].delete();
        exp_ready[0] = 1'b0;
        exp_ready[1] = 1'b0;
        repeat (2) @(negedge clk);
        rst          = 1'b1;
        exp_ready[0] = 1'b1;
        exp_ready[1] = 1'b1;
        @(negedge clk);
        send(0, 8'h3C, 1'b0);
        wait_drain(0);

        // Quiet line.
        repeat (20) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
